sfp_slf_mul: RTL and testbench

- Pipelined multiplier operating on the 26-bit internal "slf" float format.
- Sits between sfp_std2slf, which feeds both operands, and sfp_slf2std, which consumes o_dat/o_vld.
- Basic product stage of the ML datapath: weight × activation.
- Fixed latency, one result per cycle, no backpressure.

---
 rtl/sfp_pkg.sv | 30 +++
 rtl/sfp_slf_rnd.sv | 51 +++++
 rtl/sfp_slf_mul.sv | 110 +++++++++++
 tb/tb_sfp_slf_mul.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/sfp_pkg.sv
// Shared definitions for the 26-bit slf float format used across the
// std2slf / slf_mul / slf2std datapath.
package sfp_pkg;

   localparam int SLF_W    = 26;
   localparam int EXP_W    = 8;
   localparam int MAN_W    = 17;
   localparam int EXP_BIAS = 127;
   localparam int EXP_MAX  = 254;

   localparam int SGN_BIT = 25;
   localparam int EXP_HI  = 24;
   localparam int EXP_LO  = 17;
   localparam int MAN_HI  = 16;
   localparam int MAN_LO  = 0;

   // Internal widths: full mantissa product and a signed exponent with headroom
   localparam int PROD_W = 2 * MAN_W;
   localparam int EXPI_W = 10;

   localparam logic signed [EXPI_W-1:0] EXP_BIAS_S = EXPI_W'(EXP_BIAS);
   localparam logic signed [EXPI_W-1:0] EXP_MAX_S  = EXPI_W'(EXP_MAX);

   typedef struct packed {
      logic             sgn;
      logic [EXP_W-1:0] exp;
      logic [MAN_W-1:0] man;
   } slf_t;

endpackage

// File: rtl/sfp_slf_rnd.sv
// Combinational normalize + round-half-up of a mantissa product into the
// 17-bit slf mantissa, adjusting the exponent for both shifts.
module sfp_slf_rnd
   import sfp_pkg::*;
(
   input  logic        [PROD_W-1:0] prod,
   input  logic signed [EXPI_W-1:0] exp_in,
   output logic        [MAN_W-1:0]  man,
   output logic signed [EXPI_W-1:0] exp_out
);

   logic        [MAN_W-1:0]  man_raw;
   logic                     rnd_bit;
   logic signed [EXPI_W-1:0] exp_adj;
   logic        [MAN_W:0]    man_inc;

   // Bits below the rounding position never influence round-half-up.
   logic unused_low;
   assign unused_low = ^prod[14:0];

   // NOTE: every output of a combinational block gets a default first, so no
   // path can leave a value unassigned and infer a latch.
   always_comb begin
      man_raw = '0;
      rnd_bit = 1'b0;
      exp_adj = exp_in;
      man     = '0;
      exp_out = exp_in;

      if (prod[PROD_W-1]) begin
         man_raw = prod[PROD_W-1:MAN_W];
         rnd_bit = prod[MAN_W-1];
         exp_adj = exp_in + EXPI_W'(1);
      end else begin
         man_raw = prod[PROD_W-2:MAN_W-1];
         rnd_bit = prod[MAN_W-2];
      end

      man_inc = {1'b0, man_raw} + (MAN_W+1)'(rnd_bit);

      // Carry out of the mantissa renormalizes to exactly 1.0 one binade up
      if (man_inc[MAN_W]) begin
         man     = {1'b1, {(MAN_W-1){1'b0}}};
         exp_out = exp_adj + EXPI_W'(1);
      end else begin
         man     = man_inc[MAN_W-1:0];
         exp_out = exp_adj;
      end
   end

endmodule

// File: rtl/sfp_slf_mul.sv
// Four-register pipelined slf multiplier: operand capture, sign/exponent/
// product, normalize+round, range select. One result per cycle, no stall.
module sfp_slf_mul
   import sfp_pkg::*;
#(
   parameter int LAT = 3
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_req,
   input  logic [SLF_W-1:0] i_dat_a,
   input  logic [SLF_W-1:0] i_dat_b,
   output logic             o_vld,
   output logic [SLF_W-1:0] o_dat
);

   if (LAT != 3) begin : g_bad_lat
      $error("sfp_slf_mul: LAT must be 3");
   end

   // Stage 0: registered operands
   logic req0;
   slf_t a0, b0;

   // Stage 1: sign, unnormalized exponent, raw product, zero flag
   logic                     vld1, s1, z1;
   logic signed [EXPI_W-1:0] e1;
   logic        [PROD_W-1:0] p1;

   // Stage 2: normalized and rounded
   logic                     vld2, s2, z2;
   logic signed [EXPI_W-1:0] e2;
   logic        [MAN_W-1:0]  m2;

   logic signed [EXPI_W-1:0] e1_nxt, e_rnd;
   logic        [PROD_W-1:0] p1_nxt;
   logic        [MAN_W-1:0]  m_rnd;
   slf_t                     res3;

   assign e1_nxt = $signed({2'b00, a0.exp}) + $signed({2'b00, b0.exp}) - EXP_BIAS_S;
   assign p1_nxt = PROD_W'(a0.man) * PROD_W'(b0.man);

   sfp_slf_rnd u_rnd (
      .prod    (p1),
      .exp_in  (e1),
      .man     (m_rnd),
      .exp_out (e_rnd)
   );

   always_comb begin
      res3     = '0;
      res3.sgn = s2;
      if (z2 || e2 < EXPI_W'(1)) begin
         res3.exp = '0;
         res3.man = '0;
      end else if (e2 > EXP_MAX_S) begin
         res3.exp = EXP_W'(EXP_MAX);
         res3.man = '1;
      end else begin
         res3.exp = e2[EXP_W-1:0];
         res3.man = m2;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every stage
   // samples the previous stage's value from before this edge.
   // NOTE: the whole pipeline, data included, is cleared on reset so that
   // o_dat reads zero afterwards and no stale operand can leak out.
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         req0  <= 1'b0;
         a0    <= '0;
         b0    <= '0;
         vld1  <= 1'b0;
         s1    <= 1'b0;
         z1    <= 1'b0;
         e1    <= '0;
         p1    <= '0;
         vld2  <= 1'b0;
         s2    <= 1'b0;
         z2    <= 1'b0;
         e2    <= '0;
         m2    <= '0;
         o_vld <= 1'b0;
         o_dat <= '0;
      end else begin
         req0  <= i_req;
         a0    <= i_dat_a;
         b0    <= i_dat_b;

         vld1  <= req0;
         s1    <= a0.sgn ^ b0.sgn;
         z1    <= (a0.exp == '0) || (b0.exp == '0);
         e1    <= e1_nxt;
         p1    <= p1_nxt;

         vld2  <= vld1;
         s2    <= s1;
         z2    <= z1;
         e2    <= e_rnd;
         m2    <= m_rnd;

         o_vld <= vld2;
         if (vld2) begin
            o_dat <= res3;
         end
      end
   end

endmodule

// File: tb/tb_sfp_slf_mul.sv
// Self-checking bench for sfp_slf_mul: vector table through a latency-aware
// scoreboard, plus reset-mid-flight and gapped-request sequences.
module tb_sfp_slf_mul;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        i_req;
   logic [25:0] i_dat_a;
   logic [25:0] i_dat_b;
   logic        o_vld;
   logic [25:0] o_dat;

   typedef struct {
      logic [25:0] a;
      logic [25:0] b;
      logic [25:0] res;
   } vec_t;

   typedef struct {
      logic [25:0] dat;
      int          due;
   } sb_t;

   sb_t         sb[$];
   int          cyc = 0;
   int          n_cmp = 0;
   int          n_err = 0;
   logic [25:0] last_dat = '0;

   sfp_slf_mul #(.LAT(3)) dut (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_req   (i_req),
      .i_dat_a (i_dat_a),
      .i_dat_b (i_dat_b),
      .o_vld   (o_vld),
      .o_dat   (o_dat)
   );

   always #5 i_clk = ~i_clk;

   always @(posedge i_clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, req);
      end
   endtask

   // Drive one cycle on the falling edge; a request is expected back four
   // rising edges after this point (sampled on the next edge, result at +3).
   task automatic drive(input logic [25:0] a, input logic [25:0] b,
                        input logic [25:0] res, input logic req, input logic rst);
      @(negedge i_clk);
      i_req   = req;
      i_dat_a = a;
      i_dat_b = b;
      i_rst   = rst;
      if (!rst) begin
         sb.delete();
         last_dat = '0;
      end else if (req) begin
         sb.push_back('{dat: res, due: cyc + 4});
      end
   endtask

   // Monitor: sample 1 time unit after each rising edge
   always @(posedge i_clk) begin
      #1;
      if (o_vld) begin
         if (sb.size() == 0) begin
            check("unexpected_vld", 32'(o_vld), 32'd0);
         end else begin
            sb_t e;
            e = sb.pop_front();
            check("latency", 32'(cyc), 32'(e.due));
            check("o_dat", 32'(o_dat), 32'(e.dat));
            last_dat = e.dat;
         end
      end else begin
         check("hold", 32'(o_dat), 32'(last_dat));
         if (sb.size() != 0 && sb[0].due <= cyc) begin
            sb_t e;
            e = sb.pop_front();
            check("missing_vld", 32'(o_vld), 32'd1);
         end
      end
   end

   vec_t vecs[$];

   initial begin
      i_rst   = 1'b0;
      i_req   = 1'b0;
      i_dat_a = '0;
      i_dat_b = '0;

      vecs = '{
         '{a: 26'h0FF0000, b: 26'h0FF0000, res: 26'h0FF0000},  // 1.0 * 1.0
         '{a: 26'h0FF8000, b: 26'h0FF8000, res: 26'h1012000},  // 1.5^2, p[33] path
         '{a: 26'h2FF0000, b: 26'h1010000, res: 26'h3010000},  // -1 * 2
         '{a: 26'h0000000, b: 26'h1010000, res: 26'h0000000},  // zero operand
         '{a: 26'h0410000, b: 26'h0410000, res: 26'h0000000},  // underflow flush
         '{a: 26'h2000000, b: 26'h0FF0000, res: 26'h2000000},  // negative zero
         '{a: 26'h1E10000, b: 26'h1E10000, res: 26'h1FDFFFF},  // saturate
         '{a: 26'h0FF0001, b: 26'h0FF8000, res: 26'h0FF8002},  // round up
         '{a: 26'h0FF8000, b: 26'h0FF5555, res: 26'h1010000},  // round carry out
         '{a: 26'h0FF0000, b: 26'h1FD0000, res: 26'h1FD0000},  // e = 254
         '{a: 26'h1010000, b: 26'h1FD0000, res: 26'h1FDFFFF},  // e = 255
         '{a: 26'h0810000, b: 26'h0810000, res: 26'h0030000},  // e = 1
         '{a: 26'h0810000, b: 26'h07F0000, res: 26'h0000000},  // e = 0
         '{a: 26'h2410000, b: 26'h0410000, res: 26'h2000000},  // signed flush
         '{a: 26'h2FF8000, b: 26'h2FF8000, res: 26'h1012000}   // neg * neg
      };

      drive('0, '0, '0, 1'b0, 1'b0);
      drive('0, '0, '0, 1'b0, 1'b0);
      drive('0, '0, '0, 1'b0, 1'b1);
      check("rst_vld", 32'(o_vld), 32'd0);
      check("rst_dat", 32'(o_dat), 32'd0);

      // Isolated first request, then the whole table back-to-back
      drive(vecs[0].a, vecs[0].b, vecs[0].res, 1'b1, 1'b1);
      repeat (5) drive('0, '0, '0, 1'b0, 1'b1);
      foreach (vecs[i]) drive(vecs[i].a, vecs[i].b, vecs[i].res, 1'b1, 1'b1);
      repeat (5) drive(26'h3FFFFFF, 26'h3FFFFFF, '0, 1'b0, 1'b1);

      // Reset one cycle after three in-flight requests; the request presented
      // with reset low must also be dropped
      drive(26'h0FF8000, 26'h0FF8000, 26'h1012000, 1'b1, 1'b1);
      drive(26'h2FF0000, 26'h1010000, 26'h3010000, 1'b1, 1'b1);
      drive(26'h1E10000, 26'h1E10000, 26'h1FDFFFF, 1'b1, 1'b1);
      drive(26'h0FF0000, 26'h0FF0000, 26'h0FF0000, 1'b1, 1'b0);
      drive('0, '0, '0, 1'b0, 1'b1);
      check("post_rst_dat", 32'(o_dat), 32'd0);
      repeat (4) drive('0, '0, '0, 1'b0, 1'b1);

      // Fresh request after release, then gapped requests
      drive(26'h2FF0000, 26'h1010000, 26'h3010000, 1'b1, 1'b1);
      drive('0, '0, '0, 1'b0, 1'b1);
      drive(26'h0FF8000, 26'h0FF8000, 26'h1012000, 1'b1, 1'b1);
      drive('0, '0, '0, 1'b0, 1'b1);
      drive('0, '0, '0, 1'b0, 1'b1);
      drive(26'h0FF0001, 26'h0FF8000, 26'h0FF8002, 1'b1, 1'b1);

      for (int k = 0; k < 20 && sb.size() != 0; k++) drive('0, '0, '0, 1'b0, 1'b1);
      repeat (3) drive('0, '0, '0, 1'b0, 1'b1);
      check("drain", 32'(sb.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
